float_discriminant_issuer: RTL

//  Initiator side of the float_discriminant arg/res protocol.

---
 rtl/float_discriminant_issuer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/float_discriminant_issuer.sv
// rtl/float_discriminant_issuer.sv - initiator that buffers (a,b,c) triples and issues them to a float_discriminant
//
// Purpose:
//    Accepts coefficient triples on an upstream valid/ready stream into a DEPTH-entry FIFO,
//    issues them one at a time to a multi-cycle float_discriminant and returns each result
//    (or a timeout marker) on a downstream valid/ready stream, in issue order.
//
// Parameters:
//    FLEN     float width (64 = double)
//    DEPTH    input FIFO entries, power of 2, >= 2
//    TIMEOUT  cycles after disc_arg_vld at which a missing result becomes a timeout marker, >= 2
//
// Ports:
//    clk, rst                  clock, synchronous active-high reset
//    in_vld/in_rdy/in_a/b/c    upstream triple stream (in_rdy = FIFO not full, 0 during rst)
//    disc_arg_vld, disc_a/b/c  one-cycle issue strobe and registered operands
//    disc_busy, disc_res_vld,
//    disc_res, disc_res_negative,
//    disc_err                  discriminant status and result
//    out_vld/out_rdy           downstream result handshake
//    out_res, out_negative,
//    out_err, out_timeout      captured result fields (timeout: res=0, err=1, timeout=1)
//
// Configuration:
//    FLOAT_DISC_ISSUER_STATS_EN  adds 32-bit wrapping counters stat_issued, stat_err, stat_timeout
module float_discriminant_issuer #(
   parameter int FLEN    = 64,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_vld,
   output logic            in_rdy,
   input  logic [FLEN-1:0] in_a,
   input  logic [FLEN-1:0] in_b,
   input  logic [FLEN-1:0] in_c,
   output logic            disc_arg_vld,
   output logic [FLEN-1:0] disc_a,
   output logic [FLEN-1:0] disc_b,
   output logic [FLEN-1:0] disc_c,
   input  logic            disc_busy,
   input  logic            disc_res_vld,
   input  logic [FLEN-1:0] disc_res,
   input  logic            disc_res_negative,
   input  logic            disc_err,
   output logic            out_vld,
   input  logic            out_rdy,
   output logic [FLEN-1:0] out_res,
   output logic            out_negative,
   output logic            out_err,
   output logic            out_timeout
`ifdef FLOAT_DISC_ISSUER_STATS_EN
   ,
   output logic [31:0]     stat_issued,
   output logic [31:0]     stat_err,
   output logic [31:0]     stat_timeout
`endif
);

   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [FLEN-1:0] r_mem_a [DEPTH];
   logic [FLEN-1:0] r_mem_b [DEPTH];
   logic [FLEN-1:0] r_mem_c [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CNTW-1:0] r_count;

   logic [TW-1:0]   r_wait_cnt;
   logic [FLEN-1:0] r_disc_a;
   logic [FLEN-1:0] r_disc_b;
   logic [FLEN-1:0] r_disc_c;
   logic [FLEN-1:0] r_out_res;
   logic            r_out_negative;
   logic            r_out_err;
   logic            r_out_timeout;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_term;
   logic w_arg_vld;
   logic w_out_vld;

   assign w_full  = (r_count == CNTW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign in_rdy  = !rst && !w_full;
   assign w_push  = in_vld && in_rdy;

   // Last WAIT cycle before the timeout: the counter would step to TIMEOUT-1 on this edge,
   // which puts out_vld exactly TIMEOUT cycles after disc_arg_vld.
   assign w_term = (r_wait_cnt == TW'(TIMEOUT - 2));

   // ---------------- FIFO ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNTW'(1);
            2'b01:   r_count <= r_count - CNTW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_a[r_wr_ptr] <= in_a;
         r_mem_b[r_wr_ptr] <= in_b;
         r_mem_c[r_wr_ptr] <= in_c;
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_pop) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT:  if (disc_res_vld || w_term) w_state_nxt = S_HOLD;
         S_HOLD:  if (out_rdy) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Gating the pop on !disc_busy keeps a late result from a timed-out op from being
   // mistaken for the next op's result.
   always_comb begin
      w_pop     = 1'b0;
      w_arg_vld = 1'b0;
      w_out_vld = 1'b0;
      case (r_state)
         S_IDLE:  w_pop     = !w_empty && !disc_busy;
         S_ISSUE: w_arg_vld = 1'b1;
         S_HOLD:  w_out_vld = 1'b1;
         default: ;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt     <= '0;
         r_disc_a       <= '0;
         r_disc_b       <= '0;
         r_disc_c       <= '0;
         r_out_res      <= '0;
         r_out_negative <= 1'b0;
         r_out_err      <= 1'b0;
         r_out_timeout  <= 1'b0;
      end else begin
         if (w_pop) begin
            r_disc_a <= r_mem_a[r_rd_ptr];
            r_disc_b <= r_mem_b[r_rd_ptr];
            r_disc_c <= r_mem_c[r_rd_ptr];
         end
         case (r_state)
            S_ISSUE: r_wait_cnt <= '0;
            S_WAIT: begin
               r_wait_cnt <= r_wait_cnt + TW'(1);
               // A real result on the terminal cycle takes priority over the timeout marker.
               if (disc_res_vld) begin
                  r_out_res      <= disc_res;
                  r_out_negative <= disc_res_negative;
                  r_out_err      <= disc_err;
                  r_out_timeout  <= 1'b0;
               end else if (w_term) begin
                  r_out_res      <= '0;
                  r_out_negative <= 1'b0;
                  r_out_err      <= 1'b1;
                  r_out_timeout  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign disc_arg_vld = w_arg_vld;
   assign disc_a       = r_disc_a;
   assign disc_b       = r_disc_b;
   assign disc_c       = r_disc_c;
   assign out_vld      = w_out_vld;
   assign out_res      = r_out_res;
   assign out_negative = r_out_negative;
   assign out_err      = r_out_err;
   assign out_timeout  = r_out_timeout;

`ifdef FLOAT_DISC_ISSUER_STATS_EN
   logic [31:0] r_stat_issued;
   logic [31:0] r_stat_err;
   logic [31:0] r_stat_timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_issued  <= '0;
         r_stat_err     <= '0;
         r_stat_timeout <= '0;
      end else begin
         if (w_arg_vld) r_stat_issued <= r_stat_issued + 32'd1;
         if (w_out_vld && out_rdy) begin
            if (r_out_timeout)  r_stat_timeout <= r_stat_timeout + 32'd1;
            else if (r_out_err) r_stat_err     <= r_stat_err + 32'd1;
         end
      end
   end

   assign stat_issued  = r_stat_issued;
   assign stat_err     = r_stat_err;
   assign stat_timeout = r_stat_timeout;
`endif

endmodule
